// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue sequencer sitting in front of a 5-bit combinational ALU.
// Requests are queued in a small FIFO, then applied to the ALU one at a time.
// The select is parked on IDLE_SEL between ops so the ALU always re-evaluates.
// The result is presented downstream over a valid/ready handshake.
// Optional feature: define ALU_ISSUE_SEQ_CNT_EN to add a saturating op_count output.
module alu_issue_seq #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [3:0]  IDLE_SEL = 4'b1111,
   parameter int unsigned SETTLE   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [4:0] in_a,
   input  logic [4:0] in_b,
   output logic [3:0] alu_s,
   output logic [4:0] alu_a,
   output logic [4:0] alu_b,
   input  logic [4:0] alu_y,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_op,
   output logic [4:0] out_result,
`ifdef ALU_ISSUE_SEQ_CNT_EN
   output logic [7:0] op_count,
`endif
   output logic       busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StSetup, StApply, StResult} state_e;

   state_e        state_q, state_d;
   logic [13:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [2:0]    settle_q;

   logic       push, pop;
   logic       load_ops, start_apply, capture, release_res, last_apply;
   logic [3:0] head_op;
   logic [4:0] head_a, head_b;

   // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
   assign in_ready   = (count_q != CW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign pop        = capture;
   assign head_op    = mem[rd_ptr_q][13:10];
   assign head_a     = mem[rd_ptr_q][9:5];
   assign head_b     = mem[rd_ptr_q][4:0];
   assign last_apply = (settle_q == 3'(SETTLE - 1));
   assign busy       = (state_q != StIdle) || (count_q != '0);

   // FIFO storage write; no reset needed since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {in_op, in_a, in_b};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (!push && pop) count_q <= count_q - CW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // FSM next-state and datapath strobes.
   always_comb begin
      state_d     = state_q;
      load_ops    = 1'b0;
      start_apply = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               load_ops = 1'b1;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            start_apply = 1'b1;
            state_d     = StApply;
         end
         StApply: begin
            if (last_apply) begin
               capture = 1'b1;
               state_d = StResult;
            end
         end
         StResult: begin
            if (out_ready) begin
               release_res = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ALU drive and result capture; operands settle one cycle before the select moves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_s      <= IDLE_SEL;
         alu_a      <= '0;
         alu_b      <= '0;
         settle_q   <= '0;
         out_valid  <= 1'b0;
         out_op     <= '0;
         out_result <= '0;
      end else begin
         if (load_ops) begin
            alu_a <= head_a;
            alu_b <= head_b;
         end
         if (start_apply) begin
            alu_s    <= head_op;
            settle_q <= '0;
         end else if (state_q == StApply && !last_apply) begin
            settle_q <= settle_q + 3'd1;
         end
         if (capture) begin
            out_result <= alu_y;
            out_op     <= head_op;
            out_valid  <= 1'b1;
            alu_s      <= IDLE_SEL;
         end
         if (release_res) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUE_SEQ_CNT_EN
   // Completed-handshake counter, saturating at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (release_res && op_count != 8'hFF) begin
         op_count <= op_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with an attached ALU model that only
// re-evaluates when its select changes.
module tb_alu_issue_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [4:0] in_a, in_b;
   logic [3:0] alu_s;
   logic [4:0] alu_a, alu_b;
   logic [4:0] alu_y = 5'd0;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_op;
   logic [4:0] out_result;
   logic       busy;
`ifdef ALU_ISSUE_SEQ_CNT_EN
   logic [7:0] op_count;
`endif

   int n_pass  = 0;
   int n_total = 0;

   alu_issue_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .alu_s      (alu_s),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_result (out_result),
`ifdef ALU_ISSUE_SEQ_CNT_EN
      .op_count   (op_count),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] alu_f(input logic [3:0] s, input logic [4:0] a,
                                        input logic [4:0] b);
      case (s)
         4'b1100: return a - b;
         4'b0001: return (a > b) ? a : b;
         4'b0010: return a + b;
         4'b0011: return a ^ b;
         default: return 5'd0;
      endcase
   endfunction

   // ALU model: evaluates only on a select change.
   always @(alu_s) alu_y = alu_f(alu_s, alu_a, alu_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      logic seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 4'd0;
      in_a      = 5'd0;
      in_b      = 5'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_alu_s", 32'(alu_s), 32'hF);
      chk("rst_alu_a", 32'(alu_a), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_result", 32'(out_result), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      step();

      // Single op: latency and select sequence.
      push(4'b1100, 5'h0F, 5'h03);
      chk("t1_s_idle", 32'(alu_s), 32'hF);
      chk("t1_busy", 32'(busy), 1);
      step();
      chk("t1_s_setup", 32'(alu_s), 32'hF);
      chk("t1_alu_a", 32'(alu_a), 32'h0F);
      chk("t1_alu_b", 32'(alu_b), 32'h03);
      step();
      chk("t1_s_apply", 32'(alu_s), 32'hC);
      chk("t1_not_yet", 32'(out_valid), 0);
      step();
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_op", 32'(out_op), 32'hC);
      chk("t1_result", 32'(out_result), 32'h0C);
      chk("t1_s_park", 32'(alu_s), 32'hF);
      step();
      chk("t1_released", 32'(out_valid), 0);
      chk("t1_busy_drop", 32'(busy), 0);

      // Back-to-back identical opcodes.
      push(4'b0001, 5'd7, 5'd9);
      push(4'b0001, 5'd20, 5'd4);
      wait_valid(20, ok);
      chk("t2_first_to", 32'(ok), 1);
      chk("t2_first_res", 32'(out_result), 9);
      chk("t2_s_park", 32'(alu_s), 32'hF);
      step();
      wait_valid(20, ok);
      chk("t2_second_to", 32'(ok), 1);
      chk("t2_second_op", 32'(out_op), 1);
      chk("t2_second_res", 32'(out_result), 20);
      step();

      // Hold result while filling the FIFO; fifth request is dropped.
      out_ready = 1'b0;
      push(4'b0011, 5'h15, 5'h0A);
      wait_valid(20, ok);
      chk("t3_hold_to", 32'(ok), 1);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 5);
         in_op    = 4'b0010;
         in_a     = 5'(2 * i + 1);
         in_b     = 5'(2 * i + 2);
         step();
         chk("t4_hold_valid", 32'(out_valid), 1);
         chk("t4_hold_op", 32'(out_op), 3);
         chk("t4_hold_res", 32'(out_result), 32'h1F);
         chk("t3_in_ready", 32'(in_ready), (i >= 3) ? 0 : 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         wait_valid(20, ok);
         chk("t3_drain_to", 32'(ok), 1);
         chk("t3_drain_op", 32'(out_op), 2);
         chk("t3_drain_res", 32'(out_result), 32'(4 * k + 3));
         step();
      end
      seen = 1'b0;
      repeat (12) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      chk("t3_no_fifth", 32'(seen), 0);
      chk("t3_idle_busy", 32'(busy), 0);

      // Asynchronous reset during APPLY with entries queued.
      push(4'b0010, 5'd1, 5'd2);
      push(4'b0010, 5'd3, 5'd4);
      push(4'b0010, 5'd5, 5'd6);
      chk("t5_in_apply", 32'(alu_s), 2);
      #1 rst = 1'b1;
      #1;
      chk("t5_alu_s", 32'(alu_s), 32'hF);
      chk("t5_alu_a", 32'(alu_a), 0);
      chk("t5_alu_b", 32'(alu_b), 0);
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_in_ready", 32'(in_ready), 1);
      chk("t5_busy", 32'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         if (out_valid || busy) seen = 1'b1;
         step();
      end
      chk("t5_quiet", 32'(seen), 0);
      push(4'b0010, 5'd1, 5'd1);
      wait_valid(20, ok);
      chk("t5_new_to", 32'(ok), 1);
      chk("t5_new_res", 32'(out_result), 2);
      step();

`ifdef ALU_ISSUE_SEQ_CNT_EN
      chk("t6_cnt_start", 32'(op_count), 1);
      for (int n = 0; n < 260; n++) begin
         push(4'b0010, 5'(n), 5'd0);
         wait_valid(20, ok);
         chk("t6_op_to", 32'(ok), 1);
         step();
      end
      chk("t6_cnt_sat", 32'(op_count), 255);
      repeat (3) step();
      chk("t6_cnt_hold", 32'(op_count), 255);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequencer stage directly upstream of the 5-bit combinational ALU.
- Accepts operation requests (select code plus two 5-bit operands) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU select and operand lines one op at a time, samples the ALU result after a settle window, and presents {op, result} downstream over a second valid/ready handshake.
- The ALU re-evaluates only when its select changes, so between ops the select is parked on a neutral code. This forces a fresh evaluation even for back-to-back identical opcodes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- IDLE_SEL, 4'b1111, neutral select driven whenever no op is applied; must differ from every issued opcode.
- SETTLE, 1, cycles alu_s holds the opcode before the result is sampled; 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  FIFO can accept a request
- in_op  in  4  ALU select code
- in_a  in  5  operand A
- in_b  in  5  operand B
- alu_s  out  4  select to ALU (registered)
- alu_a  out  5  operand A to ALU (registered)
- alu_b  out  5  operand B to ALU (registered)
- alu_y  in  5  ALU result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_op  out  4  opcode of the presented result
- out_result  out  5  sampled ALU result
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty

Behaviour:
- Reset, asynchronous and active-high on clk/rst:
  - FIFO emptied (count=0, pointers=0); state=IDLE.
  - alu_s=IDLE_SEL, alu_a=0, alu_b=0.
  - out_valid=0, out_op=0, out_result=0.
  - in_ready=1, busy=0.
  - Reset asserted mid-operation discards all queued and in-flight ops; no out_valid is produced for them.
- Input handshake:
  - Push when in_valid && in_ready.
  - in_ready = (count != DEPTH), derived from registered count only.
  - A pop in the same cycle does not free a slot for a push while full.
  - in_valid while full is ignored and the data is not latched.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when not full leaves count unchanged.
- FSM states:
  - IDLE: alu_s=IDLE_SEL. If count>0, go to SETUP.
  - SETUP: alu_a/alu_b loaded from the FIFO head; alu_s stays IDLE_SEL. Go to APPLY next cycle.
  - APPLY: alu_s=head opcode, held for SETTLE cycles via a settle counter.
    - On the last APPLY cycle: out_result<=alu_y, out_op<=opcode, FIFO pop, out_valid<=1, alu_s<=IDLE_SEL.
    - Then go to RESULT.
  - RESULT: out_valid, out_op and out_result are held stable until out_ready.
    - On out_valid && out_ready: out_valid<=0, go to IDLE.
    - out_ready already high on entry still costs one RESULT cycle.
- Latency, SETTLE=1, empty FIFO, push at cycle t:
  - SETUP at t+2.
  - APPLY at t+3.
  - out_valid high at t+4.
- Throughput: one op per 3+SETTLE cycles when out_ready is held high.
- The ALU output is treated as purely combinational; no width conversion is applied and the 5-bit result is captured as-is.

Optional Feature:
- Macro: ALU_ISSUE_SEQ_CNT_EN.
- Defined:
  - Adds output port op_count, 8 bits.
  - Increments on each out_valid && out_ready handshake and saturates at 255.
  - Reset value is 0.
- Undefined: op_count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single push (op=4'b1100, A=5'h0F, B=5'h03) with an ALU model attached, out_ready=1 -> alu_s sequence 1111,1111,1100,1111; out_valid high exactly at t+4 with out_op=4'b1100, out_result=5'h0C; busy drops one cycle later.
- Two back-to-back identical ops (op=4'b0001, A=5'd7/B=5'd9, then A=5'd20/B=5'd4) -> alu_s returns to 1111 between them; results 5'd9 then 5'd20 in order.
- Fill FIFO with 5 consecutive pushes while out_ready=0 -> in_ready low after the 4th push; 5th request not latched; after releasing out_ready, exactly 4 results emerge in push order.
- Hold out_ready=0 for 10 cycles after out_valid -> out_valid, out_op and out_result stable all 10 cycles; FIFO head not consumed early.
- Assert rst during APPLY with 3 entries queued -> all outputs at reset values immediately (asynchronous); no out_valid after deassertion until new pushes.
- With ALU_ISSUE_SEQ_CNT_EN defined, complete 260 ops -> op_count reads 255 and holds.
